// File: rtl/cpu_if.sv
// Instruction-fetch port of the core: the core drives the PC and the
// instruction memory answers with the word at that address in the same cycle.
interface cpu_if;
  logic [31:0] pc;
  logic [31:0] inst;

  modport master (output pc, input inst);
  modport slave  (input pc, output inst);
endinterface

// File: rtl/cpu.sv
// Single-cycle RV32I core: one instruction fetched, executed and retired per clock.
// Holds the register file and a 512-word data memory; only the fetch port is external.
module cpu (
  input  logic  i_clk,
  input  logic  i_rst,
  cpu_if.master imem_io
);
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcReg    = 7'b0110011;

  typedef enum logic [3:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd
  } alu_op_e;
  typedef enum logic [1:0] {WbAlu, WbMem, WbPc4, WbImm} wb_sel_e;

  logic [31:0] pc_q, pc_d, pc_plus4;
  logic [31:0] rf_q [32];
  logic [31:0] dmem_q [512];

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  logic [31:0] rs1_val, rs2_val, alu_a, alu_b, alu_res, wb_data;
  logic        rf_we, mem_we, a_pc, b_imm, is_jal, is_jalr, is_br, br_taken;
  logic        br_eq, br_lt, br_gt;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic [8:0]  dm_idx;
  logic [31:0] dm_word, ld_word, ld_data, st_mask, st_data;

  assign inst        = imem_io.inst;
  assign imem_io.pc  = pc_q;
  assign opcode      = inst[6:0];
  assign rd          = inst[11:7];
  assign funct3      = inst[14:12];
  assign rs1         = inst[19:15];
  assign rs2         = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    unique case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  always_comb begin
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    a_pc    = 1'b0;
    b_imm   = 1'b1;
    imm     = imm_i;
    alu_op  = AluAdd;
    wb_sel  = WbAlu;
    is_jal  = 1'b0;
    is_jalr = 1'b0;
    is_br   = 1'b0;
    case (opcode)
      OpcLui:    begin rf_we = 1'b1; imm = imm_u; wb_sel = WbImm; end
      OpcAuipc:  begin rf_we = 1'b1; imm = imm_u; a_pc = 1'b1; end
      OpcJal:    begin rf_we = 1'b1; imm = imm_j; a_pc = 1'b1; wb_sel = WbPc4; is_jal = 1'b1; end
      OpcJalr:   if (funct3 == 3'b000) begin rf_we = 1'b1; wb_sel = WbPc4; is_jalr = 1'b1; end
      OpcBranch: begin imm = imm_b; a_pc = 1'b1; is_br = 1'b1; end
      OpcLoad:   begin rf_we = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                   wb_sel = WbMem; end
      OpcStore:  begin imm = imm_s; mem_we = (funct3 inside {3'b000, 3'b001, 3'b010}); end
      // Only shifts use bit 30 as a modifier in OP-IMM; elsewhere it is immediate data.
      OpcImm:    begin rf_we = 1'b1; alu_op = alu_dec(funct3, (funct3 == 3'b101) && inst[30]); end
      OpcReg:    begin rf_we = 1'b1; b_imm = 1'b0; alu_op = alu_dec(funct3, inst[30]); end
      default:   ;
    endcase
  end

  assign alu_a = a_pc ? pc_q : rs1_val;
  assign alu_b = b_imm ? imm : rs2_val;

  always_comb begin
    case (alu_op)
      AluSub:  alu_res = alu_a - alu_b;
      AluSll:  alu_res = alu_a << alu_b[4:0];
      AluSlt:  alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      AluSltu: alu_res = {31'b0, alu_a < alu_b};
      AluXor:  alu_res = alu_a ^ alu_b;
      AluSrl:  alu_res = alu_a >> alu_b[4:0];
      AluSra:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      AluOr:   alu_res = alu_a | alu_b;
      AluAnd:  alu_res = alu_a & alu_b;
      default: alu_res = alu_a + alu_b;
    endcase
  end

  assign br_eq = (rs1_val == rs2_val);
  assign br_lt = funct3[1] ? (rs1_val < rs2_val) : ($signed(rs1_val) < $signed(rs2_val));
  assign br_gt = !br_eq && !br_lt;

  always_comb begin
    case (funct3)
      3'b000:         br_taken = br_eq;
      3'b001:         br_taken = !br_eq;
      3'b100, 3'b110: br_taken = br_lt;
      3'b101, 3'b111: br_taken = br_eq || br_gt;
      default:        br_taken = 1'b0;
    endcase
  end

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    if (is_jalr)                         pc_d = {alu_res[31:1], 1'b0};
    else if (is_jal || (is_br && br_taken)) pc_d = alu_res;
    else                                 pc_d = pc_plus4;
  end

  // Address bits above 10 are dropped so accesses wrap within the 2 KiB array.
  assign dm_idx  = alu_res[10:2];
  assign dm_word = dmem_q[dm_idx];

  always_comb begin
    if (funct3[1:0] == 2'b01) ld_word = dm_word >> {alu_res[1], 4'b0000};
    else                      ld_word = dm_word >> {alu_res[1:0], 3'b000};
    case (funct3)
      3'b000:  ld_data = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_data = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_data = {24'b0, ld_word[7:0]};
      3'b101:  ld_data = {16'b0, ld_word[15:0]};
      default: ld_data = dm_word;
    endcase
  end

  always_comb begin
    st_mask = '1;
    st_data = rs2_val;
    if (funct3[1:0] == 2'b00) begin
      st_mask = 32'h0000_00ff << {alu_res[1:0], 3'b000};
      st_data = rs2_val << {alu_res[1:0], 3'b000};
    end else if (funct3[1:0] == 2'b01) begin
      st_mask = 32'h0000_ffff << {alu_res[1], 4'b0000};
      st_data = rs2_val << {alu_res[1], 4'b0000};
    end
  end

  always_comb begin
    unique case (wb_sel)
      WbMem:   wb_data = ld_data;
      WbPc4:   wb_data = pc_plus4;
      WbImm:   wb_data = imm;
      default: wb_data = alu_res;
    endcase
  end

  // Register file and data memory hold their contents through reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (rf_we && (rd != 5'd0)) rf_q[rd] <= wb_data;
      if (mem_we) dmem_q[dm_idx] <= (dm_word & ~st_mask) | (st_data & st_mask);
    end
  end
endmodule

// File: tb/tb_cpu.sv
// Directed-program bench for cpu: each issued instruction queues its expected
// retirement effects, and a monitor checks them just after the retiring edge.
module tb_cpu;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;
  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcImm   = 7'b0010011;

  typedef struct {
    string       nm;
    logic [31:0] pc;
    int          rd;
    logic [31:0] rv;
    int          ma;
    logic [31:0] mv;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [31:0] pc_m;
  exp_t sb_q[$];

  cpu_if imem_if ();

  cpu dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .imem_io (imem_if)
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, req);
    end
  endfunction

  function automatic logic [31:0] i_ins(int imm, int rs1, int f3, int rd, logic [6:0] opc);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc};
  endfunction
  function automatic logic [31:0] r_ins(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] s_ins(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_ins(int imm, int rs1, int rs2, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] u_ins(int imm, int rd, logic [6:0] opc);
    return {imm[19:0], rd[4:0], opc};
  endfunction
  function automatic logic [31:0] j_ins(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return i_ins(imm, rs1, 0, rd, OpcImm);
  endfunction

  // Drive an instruction and queue what must be true after it retires.
  task automatic issue(input string nm, input logic [31:0] ins, input logic [31:0] nxt,
                       input int rd, input logic [31:0] rv, input int ma, input logic [31:0] mv);
    exp_t e;
    imem_if.inst = ins;
    e.nm = nm; e.pc = nxt; e.rd = rd; e.rv = rv; e.ma = ma; e.mv = mv;
    sb_q.push_back(e);
    pc_m = nxt;
  endtask

  task automatic run(input string nm, input logic [31:0] ins, input logic [31:0] nxt,
                     input int rd, input logic [31:0] rv, input int ma, input logic [31:0] mv);
    issue(nm, ins, nxt, rd, rv, ma, mv);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input string nm, input logic [31:0] ins, input int rd, input logic [31:0] rv);
    run(nm, ins, pc_m + 32'd4, rd, rv, -1, 32'h0);
  endtask

  task automatic store(input string nm, input logic [31:0] ins, input int ma, input logic [31:0] mv);
    run(nm, ins, pc_m + 32'd4, -1, 32'h0, ma, mv);
  endtask

  task automatic jump(input string nm, input logic [31:0] ins, input logic [31:0] nxt,
                      input int rd, input logic [31:0] rv);
    run(nm, ins, nxt, rd, rv, -1, 32'h0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({e.nm, "_pc"}, imem_if.pc, e.pc);
      if (e.rd > 0) check({e.nm, "_rd"}, dut.rf_q[e.rd], e.rv);
      if (e.ma >= 0) check({e.nm, "_mem"}, dut.dmem_q[e.ma >> 2], e.mv);
    end
  end

  initial begin
    rst = 1'b1;
    imem_if.inst = 32'h0000_0013;
    pc_m = 32'h0;
    @(negedge clk);
    check("reset_pc", imem_if.pc, 32'h0);
    rst = 1'b0;

    // Arithmetic basics
    step("addi_x5", addi(5, 0, 3), 5, 32'd3);
    step("addi_x24", addi(24, 0, 5), 24, 32'd5);
    step("add", r_ins(0, 24, 5, 0, 1), 1, 32'd8);
    step("addi_neg", addi(2, 0, -118), 2, 32'hFFFF_FF8A);
    step("addi_x3", addi(3, 0, 4), 3, 32'd4);
    step("sra", r_ins(32, 3, 2, 5, 1), 1, 32'hFFFF_FFF8);
    step("addi_x18", addi(18, 0, 12), 18, 32'd12);
    step("addi_1234", addi(3, 18, 1234), 3, 32'd1246);
    step("addi_x7", addi(7, 0, 9), 7, 32'd9);
    step("x0_write", addi(0, 0, 5), -1, 32'h0);
    step("x0_reads_0", r_ins(0, 0, 0, 0, 7), 7, 32'd0);
    step("rd_eq_rs1", addi(7, 7, 1), 7, 32'd1);

    // Byte/word loads from address 0
    step("lui", u_ins(32'hDEADC, 1, OpcLui), 1, 32'hDEAD_C000);
    step("addi_lo", addi(1, 1, -273), 1, 32'hDEAD_BEEF);
    store("sw0", s_ins(0, 1, 0, 2), 0, 32'hDEAD_BEEF);
    step("lw", i_ins(0, 0, 2, 4, OpcLoad), 4, 32'hDEAD_BEEF);
    step("lb3", i_ins(3, 0, 0, 4, OpcLoad), 4, 32'hFFFF_FFDE);
    step("lb0", i_ins(0, 0, 0, 4, OpcLoad), 4, 32'hFFFF_FFEF);
    step("lbu1", i_ins(1, 0, 4, 4, OpcLoad), 4, 32'h0000_00BE);

    // Halfword loads at 16, plus address wrap above 2 KiB
    step("lui_cafe", u_ins(32'hCAFEB, 1, OpcLui), 1, 32'hCAFE_B000);
    step("addi_b0ba", addi(1, 1, 32'h0BA), 1, 32'hCAFE_B0BA);
    step("addi_x2_16", addi(2, 0, 16), 2, 32'd16);
    store("sw16", s_ins(0, 1, 2, 2), 16, 32'hCAFE_B0BA);
    step("lhu2", i_ins(2, 2, 5, 4, OpcLoad), 4, 32'h0000_CAFE);
    step("lh2", i_ins(2, 2, 1, 4, OpcLoad), 4, 32'hFFFF_CAFE);
    step("lh0", i_ins(0, 2, 1, 4, OpcLoad), 4, 32'hFFFF_B0BA);
    step("lh1_a0_ignored", i_ins(1, 2, 1, 4, OpcLoad), 4, 32'hFFFF_B0BA);
    step("lhu3", i_ins(3, 2, 5, 4, OpcLoad), 4, 32'h0000_CAFE);
    step("lui_x6", u_ins(1, 6, OpcLui), 6, 32'h0000_1000);
    step("lw_wrap", i_ins(16, 6, 2, 4, OpcLoad), 4, 32'hCAFE_B0BA);

    // Stores into word at 8
    step("addi_x2_8", addi(2, 0, 8), 2, 32'd8);
    step("lui_dead", u_ins(32'hDEADC, 1, OpcLui), 1, 32'hDEAD_C000);
    step("addi_beef", addi(1, 1, -273), 1, 32'hDEAD_BEEF);
    store("sw8_init", s_ins(0, 1, 2, 2), 8, 32'hDEAD_BEEF);
    step("lui_cafe2", u_ins(32'hCAFEB, 1, OpcLui), 1, 32'hCAFE_B000);
    step("addi_b0ba2", addi(1, 1, 32'h0BA), 1, 32'hCAFE_B0BA);
    issue("sw8", s_ins(0, 1, 2, 2), pc_m + 32'd4, -1, 32'h0, 8, 32'hCAFE_B0BA);
    #1 check("sw8_pre_edge", dut.dmem_q[2], 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    store("sh8_2", s_ins(2, 1, 2, 1), 8, 32'hB0BA_B0BA);
    store("sb8_1", s_ins(1, 1, 2, 0), 8, 32'hB0BA_BABA);
    store("sb8_3", s_ins(3, 1, 2, 0), 8, 32'hBABA_BABA);

    // ALU operations
    step("addi_m1", addi(11, 0, -1), 11, 32'hFFFF_FFFF);
    step("addi_5", addi(12, 0, 5), 12, 32'd5);
    step("sub", r_ins(32, 11, 12, 0, 13), 13, 32'd6);
    step("slt", r_ins(0, 12, 11, 2, 13), 13, 32'd1);
    step("sltu", r_ins(0, 12, 11, 3, 13), 13, 32'd0);
    step("slti", i_ins(0, 11, 2, 13, OpcImm), 13, 32'd1);
    step("sltiu", i_ins(-1, 12, 3, 13, OpcImm), 13, 32'd1);
    step("xori", i_ins(-1, 12, 4, 13, OpcImm), 13, 32'hFFFF_FFFA);
    step("ori", i_ins(32'h30, 12, 6, 13, OpcImm), 13, 32'h35);
    step("andi", i_ins(32'h7F0, 11, 7, 13, OpcImm), 13, 32'h7F0);
    step("slli", i_ins(28, 12, 1, 13, OpcImm), 13, 32'h5000_0000);
    step("srli", i_ins(28, 11, 5, 13, OpcImm), 13, 32'hF);
    step("srai", i_ins(32'h410, 1, 5, 13, OpcImm), 13, 32'hFFFF_CAFE);
    step("sll", r_ins(0, 12, 12, 1, 13), 13, 32'hA0);
    step("srl", r_ins(0, 12, 11, 5, 13), 13, 32'h07FF_FFFF);
    step("xor", r_ins(0, 12, 11, 4, 13), 13, 32'hFFFF_FFFA);
    step("or", r_ins(0, 3, 12, 6, 13), 13, 32'h4DF);
    step("and", r_ins(0, 11, 3, 7, 13), 13, 32'h4DE);
    step("add_self", r_ins(0, 12, 12, 0, 12), 12, 32'd10);
    step("fence_nop", 32'h0000_000F, 13, 32'h4DE);
    step("ecall_nop", 32'h0000_0073, 13, 32'h4DE);
    step("unknown_nop", 32'h0000_007F, 13, 32'h4DE);

    // Control flow
    step("lui_x9", u_ins(32'hD, 9, OpcLui), 9, 32'h0000_D000);
    step("addi_cafe", addi(9, 9, -1282), 9, 32'h0000_CAFE);
    step("clr_x1", addi(1, 0, 0), 1, 32'd0);
    step("addi_x2_4c", addi(2, 0, 32'h4C), 2, 32'h4C);
    jump("jal_to_24", j_ins(32'h24 - pc_m, 0), 32'h24, -1, 32'h0);
    jump("beq_hold", b_ins(0, 1, 0, 0), 32'h24, -1, 32'h0);
    jump("beq_nt", b_ins(0, 9, 0, 0), 32'h28, -1, 32'h0);
    jump("jal", j_ins(16, 1), 32'h38, 1, 32'h2C);
    jump("jalr", i_ins(4, 2, 0, 1, OpcJalr), 32'h50, 1, 32'h3C);
    jump("jalr_lsb", i_ins(1, 2, 0, 0, OpcJalr), 32'h4C, -1, 32'h0);
    jump("bne_back", b_ins(-8, 9, 0, 1), 32'h44, -1, 32'h0);
    jump("blt_nt", b_ins(8, 2, 11, 4), 32'h48, -1, 32'h0);
    jump("bltu_t", b_ins(8, 2, 11, 6), 32'h50, -1, 32'h0);
    jump("bge_nt", b_ins(8, 11, 2, 5), 32'h54, -1, 32'h0);
    jump("bgeu_t", b_ins(-16, 11, 2, 7), 32'h44, -1, 32'h0);
    jump("bge_eq", b_ins(8, 2, 2, 5), 32'h4C, -1, 32'h0);
    jump("blt_t", b_ins(-8, 11, 2, 4), 32'h44, -1, 32'h0);
    step("auipc", u_ins(1, 4, OpcAuipc), 4, 32'h0000_1044);

    // Asynchronous reset mid-run: PC clears at once and a pending store is suppressed
    imem_if.inst = s_ins(0, 12, 0, 2);
    #1 rst = 1'b1;
    #1 check("rst_async_pc", imem_if.pc, 32'h0);
    @(posedge clk);
    #1 check("rst_hold_pc", imem_if.pc, 32'h0);
    check("rst_no_store", dut.dmem_q[0], 32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b0;
    pc_m = 32'h0;
    step("post_rst", addi(14, 0, 7), 14, 32'd7);

    repeat (2) @(posedge clk);
    #2 check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu.md
# cpu

Single-cycle RV32I integer core: fetches one 32-bit instruction per clock from an external instruction port, executes it completely in that cycle, and retires it on the next rising edge. Owns the 31-entry register file and a 2 KiB internal data memory; the only external interfaces are the program counter out and the instruction in. It is the top of the execution datapath; instruction memory lives outside.

## Interface
- No parameters. Data memory is fixed at 512 words (2 KiB).
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- o_pc  output  32  address of the instruction being executed. Reset value 0x00000000.
- i_inst  input  32  instruction at o_pc, combinationally valid within the same cycle.

## Operation
- Decode: standard RV32I encodings. Immediate formats are I, S, B, U and J, each sign-extended to 32 bits.
- Supported classes:
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- FENCE, SYSTEM and unknown opcodes execute as NOP: PC+4, no register or memory write.
- Register file:
  - x0 reads 0; writes to x0 are discarded. x1..x31 are 32-bit.
  - Two combinational read ports, one synchronous write port.
  - Not cleared by reset.
- ALU:
  - Add/sub, shifts by operand_b[4:0] (SRA arithmetic), signed/unsigned less-than, XOR/OR/AND.
  - Operand A is rs1, or PC for AUIPC/JAL/branch target. Operand B is rs2 or the immediate.
- Branch compare: a separate comparator on rs1/rs2 yields eq, lt and gt, using signed or unsigned compare per funct3.
- Next PC:
  - Taken branch or JAL: PC+imm.
  - JALR: (rs1+imm) & ~1.
  - Otherwise: PC+4.
  - A branch offset of 0 holds the PC.
- JAL/JALR write rd = PC+4.
- Data memory address:
  - Effective address = rs1+imm.
  - Word index = addr[10:2]; address bits above 10 are ignored (wrap within 2 KiB).
  - Lane select: byte uses addr[1:0]. Halfword uses addr[1] (addr[0] ignored). Word ignores addr[1:0].
- Byte lane mapping: byte offset k occupies bits [8k+7:8k]. Example: byte 3 is [31:24]; halfword at offset 2 is [31:16].
- Loads: read the word combinationally, mask to the lane, shift down to bit 0, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Stores:
  - Store data is rs2 shifted up into the selected lane, with a 32-bit write mask covering that lane.
  - On the clock edge, only the masked bits of the word change.
- Data memory is not cleared by reset; its contents are undefined until written.

## Timing
- Combinational path within a cycle: o_pc → i_inst → decode → register read → ALU / memory read → writeback data and next PC.
- Rising edge: PC ← next PC; rd written if the instruction writes a register; memory word updated if a store.
- Latency: one instruction per cycle. No stalls, no hazards, no forwarding needed.
- Reset: asserting i_rst forces o_pc to 0 immediately, regardless of clock. While reset is held, no register or memory writes occur. Execution starts at 0 on the first rising edge after deassertion.
- An instruction whose rs1 or rs2 equals its rd reads the old value; the new value is visible from the next cycle.

## Test plan
- Reset, then ADD x1,x5,x24 with x5=3 and x24=5 → x1=8, o_pc=4. Then SRA x1,x2,x3 with x2=0xFFFFFF8A and x3=4 → x1=0xFFFFFFF8.
- ADDI x3,x18,1234 with x18=12 → x3=1246.
- Loads with mem[0]=0xDEADBEEF:
  - LW x1,0(x0) → 0xDEADBEEF.
  - LB x1,3(x0) → 0xFFFFFFDE.
- Halfword loads with mem[16]=0xCAFEB0BA and x2=16:
  - LHU x1,2(x2) → 0x0000CAFE.
  - LH x1,2(x2) → 0xFFFFCAFE.
- Stores with x2=8 and mem[8]=0xDEADBEEF:
  - SW x1=0xCAFEB0BA → mem[8]=0xCAFEB0BA, unchanged until the edge.
  - Then SH x1=0xB0BA at offset 2 → mask 0xFFFF0000, mem[8]=0xB0BAB0BA.
- Control flow starting at PC=0x24:
  - BEQ x1,x0,0 with x1=0 → PC stays 0x24. With x1=0xCAFE → PC=0x28.
  - JAL x1,16 at PC 0x28 → x1=0x2C, PC=0x38.
  - JALR x1,4(x2) with x2=0x4C → x1=0x3C, PC=0x50.
